// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges ALU (A) and load-unit (B) writebacks onto a
// single register-file write port. Each requester has a one-entry buffer, and
// one buffer drains per cycle. The block also publishes a pending-destination
// mask and a decode hazard, and counts cycles in which both buffers compete.
// Optional macro REGFILE_ARB_RR_EN: tie cycles use round-robin arbitration
// instead of fixed priority A over B.
module regfile_write_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    input  logic [4:0]      a_dest,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_dest,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic [4:0]      src_one,
    input  logic [4:0]      src_two,
    output logic            wr_en,
    output logic [4:0]      wr_dest,
    output logic [XLEN-1:0] wr_data,
    output logic [31:0]     pend_mask,
    output logic            hazard,
    output logic [15:0]     contention_cnt
);

    logic            a_vld, b_vld;
    logic [4:0]      a_dst, b_dst;
    logic [XLEN-1:0] a_dat, b_dat;
    logic            tie, gnt_a, gnt_b;
    logic            a_acc, b_acc;

`ifdef REGFILE_ARB_RR_EN
    // 1 when B won the most recent tie; reset to B so A wins the first tie.
    logic            last_b;
`endif

    // Pick the buffer that drains this cycle.
    always_comb begin
        tie   = a_vld && b_vld;
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (tie) begin
`ifdef REGFILE_ARB_RR_EN
            gnt_a = last_b;
            gnt_b = !last_b;
`else
            gnt_a = 1'b1;
`endif
        end else begin
            gnt_a = a_vld;
            gnt_b = b_vld;
        end
    end

    // A buffer can take a new request when empty or when it drains this cycle.
    always_comb begin
        a_ready = !reset && (!a_vld || gnt_a);
        b_ready = !reset && (!b_vld || gnt_b);
        a_acc   = a_valid && a_ready;
        b_acc   = b_valid && b_ready;
    end

    // Register-file write port; suppressed during reset so discarded buffers never write.
    always_comb begin
        wr_en   = !reset && (a_vld || b_vld);
        wr_dest = '0;
        wr_data = '0;
        if (wr_en) begin
            if (gnt_a) begin
                wr_dest = a_dst;
                wr_data = a_dat;
            end else begin
                wr_dest = b_dst;
                wr_data = b_dat;
            end
        end
    end

    // Pending destinations and decode hazard; x0 is never pending.
    always_comb begin
        pend_mask = '0;
        if (a_vld) pend_mask[a_dst] = 1'b1;
        if (b_vld) pend_mask[b_dst] = 1'b1;
        pend_mask[0] = 1'b0;
        hazard = pend_mask[src_one] | pend_mask[src_two];
    end

    // Buffer A: refill beats drain; writes to x0 are accepted but dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld <= 1'b0;
            a_dst <= '0;
            a_dat <= '0;
        end else if (a_acc && (a_dest != 5'd0)) begin
            a_vld <= 1'b1;
            a_dst <= a_dest;
            a_dat <= a_data;
        end else if (gnt_a) begin
            a_vld <= 1'b0;
        end
    end

    // Buffer B: same behaviour as buffer A.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_vld <= 1'b0;
            b_dst <= '0;
            b_dat <= '0;
        end else if (b_acc && (b_dest != 5'd0)) begin
            b_vld <= 1'b1;
            b_dst <= b_dest;
            b_dat <= b_data;
        end else if (gnt_b) begin
            b_vld <= 1'b0;
        end
    end

    // Saturating count of cycles in which both buffers compete.
    always_ff @(posedge clk) begin
        if (reset) begin
            contention_cnt <= '0;
        end else if (tie && (contention_cnt != 16'hFFFF)) begin
            contention_cnt <= contention_cnt + 16'd1;
        end
    end

`ifdef REGFILE_ARB_RR_EN
    // Remember the tie winner; non-tie grants leave the pointer untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (tie) begin
            last_b <= gnt_b;
        end
    end
`endif

endmodule
